ensemble_vote_scheduler: RTL

- Sequences one feature-vector sample at a time through the three-classifier ensemble: gaussian NB (index 0), logistic regression (index 1) and gradient boost (index 2).
- Broadcasts each input AXI-Stream sample to all three classifier input streams. Collects one result beat from each classifier output stream.
- Emits a single majority-vote result beat downstream.
- Sits between the DMA feature stream and the classifier instances, replacing the three independent stream connections.

---
 rtl/ensemble_vote_scheduler.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ensemble_vote_scheduler.sv
// Broadcasts each feature sample to three classifiers, collects one
// result per classifier, and emits a registered majority-vote record.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   s_axis_*           feature stream in (tdata/tkeep/tvalid/tready/tlast)
//   cls_in_*           three-way broadcast of s_axis, slice i = classifier i
//   cls_out_*          three classifier result streams (tdata/tvalid/tready)
//   m_axis_*           vote record out (tkeep all ones, tlast with tvalid)
//   busy               high whenever the scheduler is not idle
module ensemble_vote_scheduler #(
  parameter int DATA_WIDTH     = 32,
  parameter int KEEP_WIDTH     = 4,
  parameter int CLASS_WIDTH    = 8,
  parameter int TIE_PRIO       = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [3*DATA_WIDTH-1:0] cls_in_tdata,
  output logic [3*KEEP_WIDTH-1:0] cls_in_tkeep,
  output logic [2:0]              cls_in_tvalid,
  input  logic [2:0]              cls_in_tready,
  output logic [2:0]              cls_in_tlast,
  input  logic [3*DATA_WIDTH-1:0] cls_out_tdata,
  input  logic [2:0]              cls_out_tvalid,
  output logic [2:0]              cls_out_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    busy
);

  localparam int CNT_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BCAST   = 2'd1;
  localparam logic [1:0] S_COLLECT = 2'd2;
  localparam logic [1:0] S_EMIT    = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [2:0]             sent_q, sent_d;
  logic [2:0]             got_q, got_d, got_cap;
  logic [CLASS_WIDTH-1:0] res_q [3];
  logic [CLASS_WIDTH-1:0] res_d [3];
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  vote_q, vote_d;

  logic [2:0]             bvalid;
  logic                   s_hs;
  logic                   eq01, eq02, eq12;
  logic                   unan, nomaj;
  logic [CLASS_WIDTH-1:0] win;
  logic                   go_emit, to_flag;

  assign cls_in_tdata  = {3{s_axis_tdata}};
  assign cls_in_tkeep  = {3{s_axis_tkeep}};
  assign cls_in_tlast  = {3{s_axis_tlast}};
  assign cls_in_tvalid = bvalid;
  assign s_hs          = s_axis_tvalid & s_axis_tready;

  assign m_axis_tvalid = (state_q == S_EMIT);
  assign m_axis_tlast  = (state_q == S_EMIT);
  assign m_axis_tkeep  = '1;
  assign m_axis_tdata  = vote_q;
  assign busy          = (state_q != S_IDLE);

  // Handshake gating and result capture.
  always_comb begin
    bvalid         = '0;
    s_axis_tready  = 1'b0;
    cls_out_tready = '0;
    got_cap        = got_q;
    for (int i = 0; i < 3; i++) res_d[i] = res_q[i];
    unique case (state_q)
      S_IDLE: cls_out_tready = 3'b111;
      S_BCAST: begin
        bvalid         = {3{s_axis_tvalid}} & ~sent_q;
        s_axis_tready  = &(sent_q | cls_in_tready);
        cls_out_tready = ~got_q;
      end
      S_COLLECT: cls_out_tready = ~got_q;
      default: ;
    endcase
    if (state_q == S_BCAST || state_q == S_COLLECT) begin
      for (int i = 0; i < 3; i++) begin
        if (cls_out_tvalid[i] && cls_out_tready[i]) begin
          res_d[i]   =
            cls_out_tdata[i*DATA_WIDTH +: CLASS_WIDTH];
          got_cap[i] = 1'b1;
        end
      end
    end
  end

  // Vote over this cycle's capture set, so a final capture
  // can be folded into the record on the same edge.
  always_comb begin
    eq01  = got_cap[0] & got_cap[1] & (res_d[0] == res_d[1]);
    eq02  = got_cap[0] & got_cap[2] & (res_d[0] == res_d[2]);
    eq12  = got_cap[1] & got_cap[2] & (res_d[1] == res_d[2]);
    unan  = eq01 & eq02;
    nomaj = 1'b0;
    win   = '0;
    if (eq01 || eq02) begin
      win = res_d[0];
    end else if (eq12) begin
      win = res_d[1];
    end else begin
      nomaj = 1'b1;
      if (got_cap[TIE_PRIO]) win = res_d[TIE_PRIO];
      else if (got_cap[0])   win = res_d[0];
      else if (got_cap[1])   win = res_d[1];
      else if (got_cap[2])   win = res_d[2];
    end
  end

  always_comb begin
    state_d = state_q;
    sent_d  = sent_q;
    got_d   = got_cap;
    cnt_d   = cnt_q;
    vote_d  = vote_q;
    go_emit = 1'b0;
    to_flag = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (s_axis_tvalid) begin
          state_d = S_BCAST;
          sent_d  = '0;
        end
      end
      S_BCAST: begin
        if (s_hs) begin
          sent_d = '0;
          if (s_axis_tlast) begin
            state_d = S_COLLECT;
            cnt_d   = '0;
          end
        end else begin
          sent_d = sent_q | (bvalid & cls_in_tready);
        end
      end
      S_COLLECT: begin
        cnt_d = cnt_q + 1'b1;
        if (&got_cap) begin
          go_emit = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          go_emit = 1'b1;
          to_flag = 1'b1;
        end
      end
      S_EMIT: begin
        if (m_axis_tready) begin
          state_d = S_IDLE;
          got_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (go_emit) begin
      state_d                  = S_EMIT;
      vote_d                   = '0;
      vote_d[CLASS_WIDTH-1:0]  = win;
      vote_d[16]               = unan;
      vote_d[17]               = nomaj;
      vote_d[18]               = to_flag;
      vote_d[21:19]            = got_cap;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sent_q  <= '0;
      got_q   <= '0;
      cnt_q   <= '0;
      vote_q  <= '0;
      for (int i = 0; i < 3; i++) res_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sent_q  <= sent_d;
      got_q   <= got_d;
      cnt_q   <= cnt_d;
      vote_q  <= vote_d;
      for (int i = 0; i < 3; i++) res_q[i] <= res_d[i];
    end
  end

endmodule
